cfu_ram_arbiter: RTL and testbench
==================================

# cfu_ram_arbiter

Shares the CFU's single Wishbone read master (`cfu_ram_*`) between two CFU-internal fetch requesters: port 0 (image/activation fetch) and port 1 (filter fetch/preload). Each read is a classic single-beat Wishbone cycle. The block grants requests round-robin, retries bus errors a bounded number of times, and aborts on timeout. Each result returns to its requester through a valid/ready response handshake. It sits between the convolution sequencer FSM and the SoC RAM bus.

## Interface
- `MAX_RETRIES`, default 2: extra attempts after `cfu_ram_err` before an error is reported to the requester.
- `TIMEOUT`, default 255: consecutive bus cycles without `ack`/`err` before the cycle is aborted (8-bit counter).
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `reqN_valid` (N=0,1)  in  1  read request pending.
- `reqN_adr`  in  30  word address (byte address [31:2]).
- `reqN_ready`  out  1  request accepted this cycle.
- `rspN_valid`  out  1  response held for requester N.
- `rspN_data`  out  32  read data (0 on error).
- `rspN_err`  out  1  read failed (retries exhausted or timeout).
- `rspN_ready`  in  1  requester consumes response.
- `cfu_ram_adr`  out  30; `cfu_ram_cyc`, `cfu_ram_stb`  out  1.
- `cfu_ram_we`  out  1  const 0; `cfu_ram_sel`  out  4  const 4'b1111; `cfu_ram_cti`  out  3  const 0; `cfu_ram_bte`  out  2  const 0; `cfu_ram_dat_mosi`  out  32  const 0.
- `cfu_ram_dat_miso`  in  32; `cfu_ram_ack`, `cfu_ram_err`  in  1.
- `busy`  out  1  state != IDLE.
- `err_count`  out  16  saturating count of `cfu_ram_err` and timeout events.

## Operation
- States: IDLE, BUS, GAP, RESP.
- IDLE:
  - Arbitrate among `reqN_valid`.
  - If only one requester is valid, grant it.
  - If both are valid, grant the port not granted last. `last_grant` resets to 1, so port 0 wins the first contention.
  - `reqN_ready` is combinational: asserted only in IDLE for the granted port.
  - On accept: latch adr and grant id, clear retry and timeout counters, go to BUS.
- BUS:
  - `cyc` and `stb` are high and `cfu_ram_adr` holds the latched address.
  - On `ack` (and no `err`): capture `dat_miso`, err=0, go to RESP.
  - On `err` (wins over a simultaneous `ack`): `err_count`++. If retry count < MAX_RETRIES, increment it and go to GAP. Otherwise data=0, err=1, go to RESP.
  - Timeout: counter reaches TIMEOUT with no ack/err. Then `err_count`++, data=0, err=1, go to RESP. No retry on timeout.
- GAP: one cycle with `cyc`/`stb` low; reset the timeout counter; go to BUS.
- RESP:
  - `rspN_valid` high for the granted port only. Data/err are stable until taken.
  - On `rspN_ready`: go to IDLE.
  - No new request is accepted while a response is held.
- `err_count` saturates at 16'hFFFF.
- Reset:
  - Asserting `reset` at any time, including mid-BUS, immediately drops `cyc`/`stb`.
  - All state returns to IDLE; all outputs go to 0 except the constant `sel`.
  - Abandoned requests are not reported.
- Reset values: `cyc`, `stb`, `adr`, `reqN_ready`, `rspN_valid`, `rspN_data`, `rspN_err`, `busy`, `err_count` = 0.

## Timing
- Accept in cycle 0; `cyc`/`stb` rise at cycle 1.
- `ack` sampled at edge k → `cyc`/`stb` low and `rsp_valid` high from cycle k+1.
- Minimum request-to-response latency: 2 cycles (zero-wait slave acks in cycle 1).
- Response consumed at edge r → IDLE at r+1. The next accept is possible in cycle r+1, so throughput is 1 read per 3 cycles minimum.
- Error retry adds 2 cycles per attempt (GAP + BUS minimum).
- `adr` never changes while `cyc` is high.

## Structure
- Package `cfu_ram_pkg`:
  - `arb_state_t` enum {IDLE, BUS, GAP, RESP}.
  - Constants `CFU_RAM_SEL_ALL` = 4'b1111, `CFU_RAM_CTI_CLASSIC` = 3'b000, `CFU_RAM_BTE_LINEAR` = 2'b00.
- Sub-module `rr_arbiter2`: combinational two-way round-robin picker with registered `last_grant` (inputs valid[1:0], update strobe; output grant id).
- The arbiter FSM, counters and datapath latches stay in `cfu_ram_arbiter`.

## Test plan
- Single request: req0 adr=30'h100, slave acks after 3 waits with 32'hDEADBEEF → `cyc` for 4 cycles, rsp0_valid, data DEADBEEF, err=0; rsp1_valid never asserts.
- Contention: req0 and req1 both valid for 4 consecutive reads, zero-wait acks → grant order 0,1,0,1; each response reaches the correct port.
- Retry: slave returns `err` twice, then ack with 32'h12345678 → 3 `cyc` pulses separated by 1-cycle gaps; data 12345678, err=0; `err_count`=2.
- Retries exhausted: `err` on every attempt → 3 attempts (MAX_RETRIES=2), rsp err=1, data=0, `err_count`=3.
- Timeout: slave never responds, TIMEOUT=255 → `cyc` drops after 255 BUS cycles; rsp err=1; `err_count`=1.
- Reset mid-BUS and backpressure: hold rsp1_ready low for 10 cycles → rsp1_valid/data stable and req0 not accepted. Pulse `reset` low during BUS → `cyc`/`stb` 0 immediately; IDLE; no response delivered.

Source files
------------

// File: rtl/cfu_ram_arbiter_pkg.sv
// Shared types and Wishbone constants for the CFU RAM read arbiter.
package cfu_ram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    GAP  = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam logic [3:0] CFU_RAM_SEL_ALL     = 4'b1111;
  localparam logic [2:0] CFU_RAM_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] CFU_RAM_BTE_LINEAR  = 2'b00;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/cfu_ram_arbiter_if.sv
// Wishbone classic read bus between the CFU arbiter (master) and SoC RAM (slave).
interface cfu_ram_arbiter_if;

  logic [29:0] adr;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_mosi;
  logic [31:0] dat_miso;
  logic        ack;
  logic        err;

  modport master (
    output adr, cyc, stb, we, sel, cti, bte, dat_mosi,
    input  dat_miso, ack, err
  );

  modport slave (
    input  adr, cyc, stb, we, sel, cti, bte, dat_mosi,
    output dat_miso, ack, err
  );

endinterface

// File: rtl/cfu_ram_arbiter_rr.sv
// Two-way round-robin picker; last_grant advances only when a grant is taken.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       update,
  output logic       grant
);

  logic last_grant;

  always_comb begin
    grant = 1'b0;
    case (valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  // Reset to 1 so port 0 wins the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/cfu_ram_arbiter.sv
// Shares one Wishbone read master between two fetch ports with retry on err and timeout abort.
module cfu_ram_arbiter
  import cfu_ram_pkg::*;
#(
  parameter int MAX_RETRIES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [29:0]          req0_adr,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [29:0]          req1_adr,
  output logic                 req1_ready,
  output logic                 rsp0_valid,
  output logic [31:0]          rsp0_data,
  output logic                 rsp0_err,
  input  logic                 rsp0_ready,
  output logic                 rsp1_valid,
  output logic [31:0]          rsp1_data,
  output logic                 rsp1_err,
  input  logic                 rsp1_ready,
  cfu_ram_arbiter_if.master    bus,
  output logic                 busy,
  output logic [15:0]          err_count
);

  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRIES);

  arb_state_t  state;
  arb_state_t  state_next;
  logic        pick;
  logic        accept;
  logic        grant_id;
  logic [29:0] adr_lat;
  logic [31:0] data_lat;
  logic        err_lat;
  logic [7:0]  retry_cnt;
  logic [7:0]  tmo_cnt;
  logic        timeout_hit;
  logic        retry_ok;
  logic        rsp_take;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .valid  ({req1_valid, req0_valid}),
    .update (accept),
    .grant  (pick)
  );

  assign accept      = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready  = accept && !pick;
  assign req1_ready  = accept && pick;
  assign timeout_hit = (state == BUS) && !bus.ack && !bus.err && (tmo_cnt == TMO_LAST);
  assign retry_ok    = (retry_cnt < RETRY_MAX);
  assign rsp_take    = (state == RESP) && (grant_id ? rsp1_ready : rsp0_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // err outranks a simultaneous ack; a timeout is never retried.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) state_next = BUS;
        else        state_next = IDLE;
      end
      BUS: begin
        if (bus.err)                      state_next = retry_ok ? GAP : RESP;
        else if (bus.ack || timeout_hit)  state_next = RESP;
        else                              state_next = BUS;
      end
      GAP:     state_next = BUS;
      RESP: begin
        if (rsp_take) state_next = IDLE;
        else          state_next = RESP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_id  <= 1'b0;
      adr_lat   <= 30'h0;
      data_lat  <= 32'h0;
      err_lat   <= 1'b0;
      retry_cnt <= 8'h0;
      tmo_cnt   <= 8'h0;
      err_count <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            grant_id  <= pick;
            adr_lat   <= pick ? req1_adr : req0_adr;
            retry_cnt <= 8'h0;
            tmo_cnt   <= 8'h0;
          end
        end
        BUS: begin
          if (bus.err) begin
            err_count <= sat_inc16(err_count);
            if (retry_ok) begin
              retry_cnt <= retry_cnt + 8'd1;
            end else begin
              data_lat <= 32'h0;
              err_lat  <= 1'b1;
            end
          end else if (bus.ack) begin
            data_lat <= bus.dat_miso;
            err_lat  <= 1'b0;
          end else if (timeout_hit) begin
            err_count <= sat_inc16(err_count);
            data_lat  <= 32'h0;
            err_lat   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        GAP:     tmo_cnt <= 8'h0;
        default: ;
      endcase
    end
  end

  assign bus.cyc      = (state == BUS);
  assign bus.stb      = (state == BUS);
  assign bus.adr      = adr_lat;
  assign bus.we       = 1'b0;
  assign bus.sel      = CFU_RAM_SEL_ALL;
  assign bus.cti      = CFU_RAM_CTI_CLASSIC;
  assign bus.bte      = CFU_RAM_BTE_LINEAR;
  assign bus.dat_mosi = 32'h0;

  assign rsp0_valid = (state == RESP) && !grant_id;
  assign rsp1_valid = (state == RESP) && grant_id;
  assign rsp0_data  = data_lat;
  assign rsp1_data  = data_lat;
  assign rsp0_err   = err_lat;
  assign rsp1_err   = err_lat;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_cfu_ram_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized reads checked against a transaction-level model of arbiter + slave.
module tb_cfu_ram_arbiter;
  import cfu_ram_pkg::*;

  localparam int MAXR = 2;
  localparam int TMO  = 255;

  // kind: 0 = ack, 1 = err, 2 = never respond, 3 = ack and err together
  typedef struct {
    int          waits;
    int          kind;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    int          port;
    logic [29:0] adr;
    int          n_err;
    bit          first_both;
    int          fin_kind;
    int          fin_waits;
    logic [31:0] fin_data;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_cycles;
    int          exp_pulses;
    int          exp_delta;
    int          rdelay;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [29:0] req0_adr = 30'h0, req1_adr = 30'h0;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic        busy;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  cfu_ram_arbiter_if bus ();

  cfu_ram_arbiter #(.MAX_RETRIES(MAXR), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(rst_n),
    .req0_valid(req0_valid), .req0_adr(req0_adr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_adr(req1_adr), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err), .rsp1_ready(rsp1_ready),
    .bus(bus), .busy(busy), .err_count(err_count)
  );

  beat_t plan [4];
  int    plan_len = 0;
  int    plan_gen = 0;
  int    total = 0;
  int    bad = 0;
  int    exp_errcnt = 0;
  bit    model_last = 1'b1;
  int    cyc_total = 0, rise_total = 0, adr_changes = 0;
  logic [29:0] adr_last = 30'h0;
  vec_t  vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Bus monitor: cycles with cyc high, cyc pulses, address changes during a cycle.
  initial begin : monitor
    bit prev_cyc;
    prev_cyc = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.cyc) begin
        cyc_total++;
        if (!prev_cyc) rise_total++;
        else if (bus.adr !== adr_last) adr_changes++;
        adr_last = bus.adr;
      end
      prev_cyc = bus.cyc;
    end
  end

  // Slave model: each cyc pulse consumes the next plan entry.
  initial begin : slave
    int    idx, cnt, gen_seen;
    bit    active;
    beat_t b;
    idx = 0; cnt = 0; gen_seen = 0; active = 1'b0;
    bus.ack = 1'b0; bus.err = 1'b0; bus.dat_miso = 32'h0;
    forever begin
      @(negedge clk);
      if (plan_gen != gen_seen) begin gen_seen = plan_gen; idx = 0; end
      if (!bus.cyc) begin
        if (active) idx++;
        active = 1'b0; bus.ack = 1'b0; bus.err = 1'b0;
      end else begin
        if (!active) begin active = 1'b1; cnt = 0; end
        b.waits = 0; b.kind = 0; b.data = 32'h0;
        if (idx < plan_len) b = plan[idx];
        bus.ack = 1'b0; bus.err = 1'b0;
        if (b.kind != 2) begin
          if (cnt >= b.waits) begin
            bus.ack = (b.kind != 1);
            bus.err = (b.kind != 0);
            bus.dat_miso = b.data;
          end else begin
            cnt++;
          end
        end
      end
    end
  end

  task automatic load_plan(input int n_err, input bit first_both, input int fin_kind,
                           input int fin_waits, input logic [31:0] fin_data);
    for (int i = 0; i < 4; i++) begin
      plan[i].waits = 0; plan[i].kind = 0; plan[i].data = 32'h0;
    end
    for (int i = 0; i < n_err && i < 4; i++) begin
      plan[i].kind = (i == 0 && first_both) ? 3 : 1;
      plan[i].data = 32'hBAD0_0000 + i;
    end
    if (n_err < 4) begin
      plan[n_err].waits = fin_waits; plan[n_err].kind = fin_kind; plan[n_err].data = fin_data;
    end
    plan_len = 4;
    plan_gen++;
  endtask

  // Transaction-level outcome of the loaded plan: up to 1+MAXR attempts.
  task automatic predict(output logic [31:0] d, output bit e, output int delta,
                         output int pulses, output int cycles);
    d = 32'h0; e = 1'b1; delta = 0; pulses = 0; cycles = 0;
    for (int i = 0; i <= MAXR; i++) begin
      pulses++;
      if (plan[i].kind == 2) begin
        cycles += TMO; delta++;
        return;
      end
      cycles += plan[i].waits + 1;
      if (plan[i].kind == 0) begin
        d = plan[i].data; e = 1'b0;
        return;
      end
      delta++;
    end
  endtask

  function automatic int pick_port(input bit v0, input bit v1);
    if (v0 && v1) return model_last ? 0 : 1;
    return v1 ? 1 : 0;
  endfunction

  task automatic run_read(input bit v0, input bit v1, input logic [29:0] a0, input logic [29:0] a1,
                          input int e_port, input logic [31:0] e_data, input bit e_err,
                          input int e_cycles, input int e_pulses, input int e_delta,
                          input int rdelay, input string nm);
    int got, n, c0, r0, ac0;
    bit ok;
    logic [31:0] hd;
    logic he;
    exp_errcnt = (exp_errcnt + e_delta > 65535) ? 65535 : exp_errcnt + e_delta;
    @(negedge clk);
    c0 = cyc_total; r0 = rise_total; ac0 = adr_changes;
    req0_valid = v0; req0_adr = a0; req1_valid = v1; req1_adr = a1;
    got = -1;
    for (n = 0; n < 8; n++) begin
      #1;
      if (req0_ready || req1_ready) begin
        got = req1_ready ? 1 : 0;
        chk({nm, "/one_ready"}, 64'(req0_ready && req1_ready), 64'd0);
        break;
      end
      @(negedge clk);
    end
    chk({nm, "/grant"}, 64'(got), 64'(e_port));
    model_last = e_port[0];
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (got < 0) return;
    n = 0;
    while (!(rsp0_valid || rsp1_valid) && n < 1000) begin @(negedge clk); n++; end
    chk({nm, "/rsp_seen"}, 64'(n < 1000), 64'd1);
    chk({nm, "/rsp_port"}, {62'd0, rsp1_valid, rsp0_valid}, 64'(2'b01 << e_port));
    hd = e_port ? rsp1_data : rsp0_data;
    he = e_port ? rsp1_err : rsp0_err;
    chk({nm, "/data"}, 64'(hd), 64'(e_data));
    chk({nm, "/err"}, 64'(he), 64'(e_err));
    chk({nm, "/cyc_cycles"}, 64'(cyc_total - c0), 64'(e_cycles));
    chk({nm, "/cyc_pulses"}, 64'(rise_total - r0), 64'(e_pulses));
    chk({nm, "/adr_stable"}, 64'(adr_changes - ac0), 64'd0);
    chk({nm, "/adr"}, 64'(adr_last), 64'(e_port ? a1 : a0));
    chk({nm, "/err_count"}, 64'(err_count), 64'(exp_errcnt));
    ok = 1'b1;
    repeat (rdelay) begin
      @(negedge clk);
      if ((e_port ? rsp1_data : rsp0_data) !== hd || (e_port ? rsp1_err : rsp0_err) !== he ||
          (e_port ? rsp1_valid : rsp0_valid) !== 1'b1) ok = 1'b0;
    end
    chk({nm, "/rsp_hold"}, 64'(ok), 64'd1);
    if (e_port == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    chk({nm, "/idle_after"}, {61'd0, busy, rsp1_valid, rsp0_valid}, 64'd0);
  endtask

  initial begin : main
    logic [31:0] pd;
    bit pe, ok, v0, v1;
    int pdelta, ppulses, pcycles, n, r;
    logic [31:0] hd;

    vecs[0] = '{0, 30'h100,      0, 1'b0, 0, 3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4,   1, 0, 0};
    vecs[1] = '{0, 30'h02A,      2, 1'b0, 0, 0, 32'h12345678, 32'h12345678, 1'b0, 3,   3, 2, 1};
    vecs[2] = '{1, 30'h3FFFFFFF, 3, 1'b0, 0, 0, 32'h0,        32'h0,        1'b1, 3,   3, 3, 2};
    vecs[3] = '{1, 30'h055,      0, 1'b0, 2, 0, 32'h0,        32'h0,        1'b1, 255, 1, 1, 0};
    vecs[4] = '{0, 30'h0AB,      1, 1'b1, 0, 2, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 4,   2, 1, 3};
    vecs[5] = '{1, 30'h1C3,      1, 1'b0, 2, 0, 32'h0,        32'h0,        1'b1, 256, 2, 2, 0};
    vecs[6] = '{1, 30'h000,      0, 1'b0, 0, 0, 32'h00000001, 32'h00000001, 1'b0, 1,   1, 0, 1};

    #2;
    chk("reset/cyc_stb", {62'd0, bus.cyc, bus.stb}, 64'd0);
    chk("reset/adr", 64'(bus.adr), 64'd0);
    chk("reset/ready", {62'd0, req1_ready, req0_ready}, 64'd0);
    chk("reset/rsp", {28'd0, rsp1_valid, rsp0_valid, rsp1_err, rsp0_err, rsp1_data}, 64'd0);
    chk("reset/busy_errcnt", {47'd0, busy, err_count}, 64'd0);
    chk("reset/sel", 64'(bus.sel), 64'hF);
    chk("reset/consts", {25'd0, bus.we, bus.cti, bus.bte, bus.dat_mosi}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Contention: both ports valid on every read, first contention goes to port 0.
    for (int i = 0; i < 4; i++) begin
      load_plan(0, 1'b0, 0, 0, 32'h1000_0000 + i);
      run_read(1'b1, 1'b1, 30'h200 + 30'(i), 30'h300 + 30'(i), i % 2, 32'h1000_0000 + i, 1'b0,
               1, 1, 0, 0, "contend");
    end

    foreach (vecs[i]) begin
      load_plan(vecs[i].n_err, vecs[i].first_both, vecs[i].fin_kind, vecs[i].fin_waits, vecs[i].fin_data);
      run_read(vecs[i].port == 0, vecs[i].port == 1, vecs[i].adr, vecs[i].adr, vecs[i].port,
               vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_cycles, vecs[i].exp_pulses,
               vecs[i].exp_delta, vecs[i].rdelay, $sformatf("vec%0d", i));
    end

    for (int it = 0; it < 40; it++) begin
      plan_len = 4;
      for (int i = 0; i < 4; i++) begin
        r = $urandom_range(0, 9);
        plan[i].waits = $urandom_range(0, 3);
        plan[i].kind  = (r < 5) ? 0 : (r < 8) ? 1 : 3;
        plan[i].data  = $urandom;
      end
      if (it % 10 == 7) plan[$urandom_range(0, 2)].kind = 2;
      plan_gen++;
      predict(pd, pe, pdelta, ppulses, pcycles);
      do begin v0 = 1'($urandom); v1 = 1'($urandom); end while (!v0 && !v1);
      run_read(v0, v1, 30'($urandom), 30'($urandom), pick_port(v0, v1), pd, pe, pcycles, ppulses,
               pdelta, $urandom_range(0, 3), $sformatf("rand%0d", it));
    end

    // Backpressure: response to port 1 held while port 0 waits.
    load_plan(0, 1'b0, 0, 1, 32'hA5A50F0F);
    @(negedge clk);
    req1_valid = 1'b1; req1_adr = 30'h1234;
    #1 chk("bp/accept1", 64'(req1_ready), 64'd1);
    model_last = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    n = 0;
    while (!rsp1_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp/rsp1_seen", 64'(rsp1_valid), 64'd1);
    req0_valid = 1'b1; req0_adr = 30'h777;
    hd = rsp1_data;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (req0_ready || !rsp1_valid || rsp0_valid || rsp1_data !== hd || rsp1_err) ok = 1'b0;
      @(negedge clk);
    end
    chk("bp/held", 64'(ok), 64'd1);
    chk("bp/data", 64'(hd), 64'hA5A50F0F);
    load_plan(0, 1'b0, 0, 0, 32'h0BADF00D);
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;
    #1 chk("bp/accept0_after", {62'd0, req1_ready, req0_ready}, 64'd1);
    model_last = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    n = 0;
    while (!rsp0_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp/rsp0_data", {31'd0, rsp0_valid, rsp0_data}, {31'd0, 1'b1, 32'h0BADF00D});
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;

    // Reset in the middle of a bus cycle.
    load_plan(0, 1'b0, 2, 0, 32'h0);
    @(negedge clk);
    req0_valid = 1'b1; req0_adr = 30'h3AB;
    #1 chk("rst/accept", 64'(req0_ready), 64'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst/cyc_before", 64'(bus.cyc), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst/cyc_stb_drop", {62'd0, bus.cyc, bus.stb}, 64'd0);
    chk("rst/state", {45'd0, busy, rsp1_valid, rsp0_valid, err_count}, 64'd0);
    chk("rst/adr", 64'(bus.adr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    exp_errcnt = 0;
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid || busy || bus.cyc) ok = 1'b0;
    end
    chk("rst/no_response", 64'(ok), 64'd1);
    load_plan(0, 1'b0, 0, 0, 32'h600DCAFE);
    run_read(1'b1, 1'b1, 30'h11, 30'h22, 0, 32'h600DCAFE, 1'b0, 1, 1, 0, 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
